booth_mac_acc: RTL and testbench
================================

# booth_mac_acc

Accumulator stage directly downstream of the 4x4 Booth multiplier. Takes each new signed 8-bit product when the multiplier's level-type `done` rises, sums LEN consecutive products into a wider signed accumulator, and offers the dot-product result on a valid/ready handshake. A one-entry skid register absorbs a product that completes while the previous sum is still waiting to be taken.

## Interface
- `PROD_W`, 8: product width; matches multiplier `res`.
- `ACC_W`, 16: accumulator and sum width; must be ≥ `PROD_W`.
- `LEN`, 4: products per sum; must be ≥ 2.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `prod_in` in PROD_W: signed product, wired to multiplier `res`.
- `prod_done` in 1: wired to multiplier `done`; a level, so only its rising edge marks a new product.
- `clr` in 1: synchronous abort of the current accumulation.
- `sum_out` out ACC_W: signed sum of LEN products.
- `sum_valid` out 1: `sum_out` is valid.
- `sum_ready` in 1: consumer accepts the sum.
- `busy` out 1: state is not IDLE.
- `count` out $clog2(LEN+1): number of products in the current accumulation.
- `ovf` out 1: sticky overflow flag; set only when saturation is compiled in.
- `err` out 1: sticky flag; a product was dropped.

## Operation
- **Capture:** `cap = prod_done & ~done_q`, where `done_q` is `prod_done` delayed one cycle. `done_q` resets to 1, so a `done` that is already high out of reset is not counted.
- **Products:** each captured product is sign-extended to ACC_W.
- **States:** IDLE, ACCUM, HOLD.
  - IDLE, on cap: `acc <= sext(prod_in)`, `count <= 1`, go to ACCUM.
  - ACCUM, on cap with `count < LEN-1`: `acc += sext`, `count++`.
  - ACCUM, on cap with `count == LEN-1`: `sum_out <= acc + sext`, `sum_valid <= 1`, `count <= LEN`, go to HOLD.
  - HOLD, on cap with pending empty: store the product in `pend`, set `pend_v`.
  - HOLD, on cap with `pend_v` already set: drop the product and set `err`.
  - HOLD, on handshake (`sum_valid & sum_ready`): `sum_valid <= 0`. Next state:
    - no `pend_v`, no cap: IDLE, `acc = 0`, `count = 0`.
    - `pend_v` only: ACCUM, `acc = sext(pend)`, `count = 1`.
    - cap only: ACCUM, `acc = sext(prod_in)`, `count = 1`.
    - `pend_v` and cap: ACCUM, `acc = sext(pend) + sext(prod_in)`, `count = 2`; if LEN == 2, go straight back to HOLD with the new sum.
  - Every handshake clears `pend_v`.
- **Priority:** `rst` > `clr` > handshake/capture.
- **`clr`:** next state IDLE; `acc`, `count`, `pend_v` and `sum_valid` are cleared; `ovf` and `err` are kept; a cap in the same cycle is discarded.
- **Sum stability:** `sum_out` is stable while `sum_valid` is high; `sum_valid` does not drop without a handshake, `clr` or `rst`.
- **Sticky flags:** `ovf` and `err` clear only on `rst`.

## Timing
- **Reset values:** `sum_out = 0`, `sum_valid = 0`, `busy = 0`, `count = 0`, `ovf = 0`, `err = 0`; internally `acc = 0`, `pend_v = 0`, `done_q = 1`, state IDLE.
- **Capture latency:** 1 cycle. The product is taken on the first edge that samples `prod_done = 1` with `done_q = 0`.
- **Sum latency:** `sum_valid` rises on the same edge that captures the LEN-th product.
- **Fastest restart:** `sum_valid` can fall and ACCUM resume on the same edge.
- **Capture spacing:** a `done` held high produces one capture only. A second capture requires `done` to fall first (the multiplier's `start` does this), so captures are at least 2 cycles apart.

## Configuration
- `BOOTH_MAC_SAT_EN` defined:
  - every add clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1];
  - any clamp sets `ovf`.
- `BOOTH_MAC_SAT_EN` undefined:
  - adds wrap modulo 2^ACC_W;
  - `ovf` is tied to 0.

## Structure
- **Package `booth_pkg`:**
  - state enum `mac_state_t` (IDLE, ACCUM, HOLD);
  - function `sext_prod`;
  - function `sat_add`, whose body is guarded by the macro.
- **Sub-module `rise_det`:** `done_q` register with a reset value parameter (1 here); outputs the `cap` pulse.

## Test plan
- **Basic sum:** LEN=4, ACC_W=16, products 6, −4, 49, −8 (each as a `done` rise) → `sum_out = 43`, `sum_valid` on the 4th capture edge, `count = 4`, `busy = 1`. After the handshake: `busy = 0`, `count = 0`.
- **Held done:** `prod_done` held high for 10 cycles, then low, then high again → exactly 2 captures.
- **Reset with done high:** `rst` asserted while `prod_done = 1`, then released with `prod_done` still high → no capture, `count = 0`.
- **Backpressure:** `sum_ready = 0` after the sum is produced, then products 5 and 7 arrive → 5 goes to pend, 7 is dropped, `err = 1`. Raising `sum_ready` → `count = 1`, `acc = 5`.
- **Saturation:** LEN=2, ACC_W=8, products 100, 100 → with `BOOTH_MAC_SAT_EN`: `sum_out = 127`, `ovf = 1`. Without it: `sum_out = −56`, `ovf = 0`.
- **Abort:** `clr` pulsed after 2 of 4 products, with a `done` rise in the same cycle → IDLE, `count = 0`, that product is discarded; the next 4 products give a correct fresh sum.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and arithmetic helpers for the Booth MAC accumulator.
// BOOTH_MAC_SAT_EN selects saturating adds in sat_add; otherwise adds wrap.
package booth_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } mac_state_t;

  // Sign-extend the low w bits of a value to the full helper width.
  function automatic logic signed [MAX_W-1:0] sext_prod(input logic [MAX_W-1:0] val,
                                                         input int w);
    int sh;
    sh = MAX_W - w;
    return $signed(val << sh) >>> sh;
  endfunction

  // Add two w-bit signed values that were sign-extended to MAX_W.
  function automatic logic signed [MAX_W-1:0] sat_add(input logic signed [MAX_W-1:0] a,
                                                       input logic signed [MAX_W-1:0] b,
                                                       input int w,
                                                       output logic ovf);
    logic signed [MAX_W-1:0] r;
`ifdef BOOTH_MAC_SAT_EN
    logic signed [MAX_W:0] s;
    logic signed [MAX_W:0] hi;
    logic signed [MAX_W:0] lo;
    s  = {a[MAX_W-1], a} + {b[MAX_W-1], b};
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    ovf = 1'b0;
    r   = s[MAX_W-1:0];
    if (s > hi) begin
      ovf = 1'b1;
      r   = hi[MAX_W-1:0];
    end else if (s < lo) begin
      ovf = 1'b1;
      r   = lo[MAX_W-1:0];
    end
`else
    ovf = 1'b0;
    r   = sext_prod(a + b, w);
`endif
    return r;
  endfunction

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector for a level-type done signal; the delayed copy
// resets to RST_VAL so a level already high out of reset is not an edge.
module rise_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_level_q;

  always_ff @(posedge clk) begin
    if (rst) r_level_q <= RST_VAL;
    else     r_level_q <= i_level;
  end

  assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/booth_mac_acc.sv
// Sums LEN consecutive Booth products and offers the result on valid/ready,
// with a one-entry skid for a product arriving while the sum waits.
// Define BOOTH_MAC_SAT_EN for saturating accumulation with a sticky ovf flag.
module booth_mac_acc
  import booth_pkg::*;
#(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN    = 4,
  localparam int CNT_W = $clog2(LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_done,
  input  logic              clr,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic              err
);

  logic                     w_cap;
  logic signed [MAX_W-1:0]  w_prod_x;
  logic signed [MAX_W-1:0]  w_acc_x;
  logic signed [MAX_W-1:0]  w_pend_x;
  logic [ACC_W-1:0]         w_sum_acc;
  logic [ACC_W-1:0]         w_sum_pend;
  logic                     w_ovf_acc;
  logic                     w_ovf_pend;

  mac_state_t               r_state;
  logic [ACC_W-1:0]         r_acc;
  logic [CNT_W-1:0]         r_count;
  logic [ACC_W-1:0]         r_sum_out;
  logic                     r_sum_valid;
  logic [PROD_W-1:0]        r_pend;
  logic                     r_pend_v;
  logic                     r_ovf;
  logic                     r_err;

  rise_det #(.RST_VAL(1'b1)) u_rise_det (
    .clk     (clk),
    .rst     (rst),
    .i_level (prod_done),
    .o_rise  (w_cap)
  );

  // Two adders: running sum + new product, and skid entry + new product.
  always_comb begin
    w_prod_x   = sext_prod(MAX_W'(prod_in), PROD_W);
    w_acc_x    = sext_prod(MAX_W'(r_acc), ACC_W);
    w_pend_x   = sext_prod(MAX_W'(r_pend), PROD_W);
    w_ovf_acc  = 1'b0;
    w_ovf_pend = 1'b0;
    w_sum_acc  = ACC_W'(sat_add(w_acc_x, w_prod_x, ACC_W, w_ovf_acc));
    w_sum_pend = ACC_W'(sat_add(w_pend_x, w_prod_x, ACC_W, w_ovf_pend));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_sum_out   <= '0;
      r_sum_valid <= 1'b0;
      r_pend      <= '0;
      r_pend_v    <= 1'b0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
    end else if (clr) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_pend_v    <= 1'b0;
      r_sum_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cap) begin
            r_acc   <= w_prod_x[ACC_W-1:0];
            r_count <= CNT_W'(1);
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_cap) begin
            if (w_ovf_acc) r_ovf <= 1'b1;
            if (r_count == CNT_W'(LEN - 1)) begin
              r_sum_out   <= w_sum_acc;
              r_sum_valid <= 1'b1;
              r_count     <= CNT_W'(LEN);
              r_state     <= HOLD;
            end else begin
              r_acc   <= w_sum_acc;
              r_count <= r_count + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (r_sum_valid && sum_ready) begin
            r_sum_valid <= 1'b0;
            r_pend_v    <= 1'b0;
            if (r_pend_v && w_cap) begin
              if (w_ovf_pend) r_ovf <= 1'b1;
              // With LEN == 2 the skid entry plus the new product is already a full sum.
              if (LEN == 2) begin
                r_sum_out   <= w_sum_pend;
                r_sum_valid <= 1'b1;
                r_count     <= CNT_W'(LEN);
                r_acc       <= '0;
              end else begin
                r_acc   <= w_sum_pend;
                r_count <= CNT_W'(2);
                r_state <= ACCUM;
              end
            end else if (r_pend_v) begin
              r_acc   <= w_pend_x[ACC_W-1:0];
              r_count <= CNT_W'(1);
              r_state <= ACCUM;
            end else if (w_cap) begin
              r_acc   <= w_prod_x[ACC_W-1:0];
              r_count <= CNT_W'(1);
              r_state <= ACCUM;
            end else begin
              r_acc   <= '0;
              r_count <= '0;
              r_state <= IDLE;
            end
          end else if (w_cap) begin
            if (!r_pend_v) begin
              r_pend   <= prod_in;
              r_pend_v <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sum_out   = r_sum_out;
  assign sum_valid = r_sum_valid;
  assign busy      = (r_state != IDLE);
  assign count     = r_count;
  assign ovf       = r_ovf;
  assign err       = r_err;

endmodule

// File: tb/tb_booth_mac_acc.sv
// Directed bench for booth_mac_acc: a LEN=4/ACC_W=16 instance for the main
// scenarios and a LEN=2/ACC_W=8 instance for overflow and the LEN==2 restart.
module tb_booth_mac_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  prod_in;
  logic        prod_done;
  logic        clr;
  logic [15:0] sum_out;
  logic        sum_valid;
  logic        sum_ready;
  logic        busy;
  logic [2:0]  count;
  logic        ovf;
  logic        err;

  logic [7:0]  d2_prod_in;
  logic        d2_prod_done;
  logic        d2_clr;
  logic [7:0]  d2_sum_out;
  logic        d2_sum_valid;
  logic        d2_sum_ready;
  logic        d2_busy;
  logic [1:0]  d2_count;
  logic        d2_ovf;
  logic        d2_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_mac_acc #(.PROD_W(8), .ACC_W(16), .LEN(4)) dut (
    .clk(clk), .rst(rst), .prod_in(prod_in), .prod_done(prod_done), .clr(clr),
    .sum_out(sum_out), .sum_valid(sum_valid), .sum_ready(sum_ready), .busy(busy),
    .count(count), .ovf(ovf), .err(err)
  );

  booth_mac_acc #(.PROD_W(8), .ACC_W(8), .LEN(2)) dut2 (
    .clk(clk), .rst(rst), .prod_in(d2_prod_in), .prod_done(d2_prod_done), .clr(d2_clr),
    .sum_out(d2_sum_out), .sum_valid(d2_sum_valid), .sum_ready(d2_sum_ready), .busy(d2_busy),
    .count(d2_count), .ovf(d2_ovf), .err(d2_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rise(input int val);
    prod_in   = 8'(val);
    prod_done = 1'b1;
    tick();
  endtask

  task automatic fall();
    prod_done = 1'b0;
    tick();
  endtask

  task automatic handshake();
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (sum_out !== 16'd0) begin n_err++; $display("FAIL reset_sum_out: got %0d want 0", sum_out); end
    n_cmp++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL reset_sum_valid: got %b want 0", sum_valid); end
    n_cmp++; if (busy !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL reset_busy_count: got busy=%b count=%0d want 0/0", busy, count); end
    n_cmp++; if (ovf !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL reset_flags: got ovf=%b err=%b want 0/0", ovf, err); end
    $display("reset: sum_out=%0d valid=%b busy=%b count=%0d", sum_out, sum_valid, busy, count);
  endtask

  task automatic test_reset_done_high();
    prod_in   = 8'd9;
    prod_done = 1'b1;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    n_cmp++; if (count !== 3'd0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_done_high: got count=%0d busy=%b want 0/0", count, busy); end
    prod_done = 1'b0;
    tick();
    $display("reset with done high: count=%0d", count);
  endtask

  task automatic test_basic_sum();
    rise(6);
    n_cmp++; if (count !== 3'd1 || busy !== 1'b1) begin n_err++; $display("FAIL basic_first_cap: got count=%0d busy=%b want 1/1", count, busy); end
    fall();
    rise(-4); fall();
    rise(49); fall();
    n_cmp++; if (count !== 3'd3 || sum_valid !== 1'b0) begin n_err++; $display("FAIL basic_three: got count=%0d valid=%b want 3/0", count, sum_valid); end
    rise(-8);
    n_cmp++; if (sum_valid !== 1'b1 || sum_out !== 16'd43) begin n_err++; $display("FAIL basic_sum: got valid=%b sum=%0d want 1/43", sum_valid, $signed(sum_out)); end
    n_cmp++; if (count !== 3'd4 || busy !== 1'b1) begin n_err++; $display("FAIL basic_hold: got count=%0d busy=%b want 4/1", count, busy); end
    fall();
    handshake();
    n_cmp++; if (sum_valid !== 1'b0 || busy !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL basic_after_hs: got valid=%b busy=%b count=%0d want 0/0/0", sum_valid, busy, count); end
    n_cmp++; if (err !== 1'b0 || ovf !== 1'b0) begin n_err++; $display("FAIL basic_flags: got err=%b ovf=%b want 0/0", err, ovf); end
    $display("basic sum: 6 -4 49 -8 -> 43 taken");
  endtask

  task automatic test_held_done();
    prod_in   = 8'd3;
    prod_done = 1'b1;
    repeat (10) tick();
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL held_one_cap: got count=%0d want 1", count); end
    prod_done = 1'b0;
    tick();
    rise(2);
    n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL held_two_caps: got count=%0d want 2", count); end
    fall();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++; if (count !== 3'd0 || busy !== 1'b0) begin n_err++; $display("FAIL held_clr: got count=%0d busy=%b want 0/0", count, busy); end
    $display("held done: captures counted=2");
  endtask

  task automatic test_backpressure();
    rise(1); fall();
    rise(2); fall();
    rise(3); fall();
    rise(4); fall();
    n_cmp++; if (sum_valid !== 1'b1 || sum_out !== 16'd10) begin n_err++; $display("FAIL bp_sum: got valid=%b sum=%0d want 1/10", sum_valid, $signed(sum_out)); end
    rise(5); fall();
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL bp_pend_no_err: got err=%b want 0", err); end
    rise(7); fall();
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL bp_drop_err: got err=%b want 1", err); end
    n_cmp++; if (sum_valid !== 1'b1 || sum_out !== 16'd10 || count !== 3'd4) begin n_err++; $display("FAIL bp_stable: got valid=%b sum=%0d count=%0d want 1/10/4", sum_valid, $signed(sum_out), count); end
    handshake();
    n_cmp++; if (count !== 3'd1 || busy !== 1'b1 || sum_valid !== 1'b0) begin n_err++; $display("FAIL bp_resume: got count=%0d busy=%b valid=%b want 1/1/0", count, busy, sum_valid); end
    rise(10); fall();
    rise(20); fall();
    rise(-1); fall();
    n_cmp++; if (sum_valid !== 1'b1 || sum_out !== 16'd34) begin n_err++; $display("FAIL bp_pend_sum: got valid=%b sum=%0d want 1/34", sum_valid, $signed(sum_out)); end
    handshake();
    n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL bp_err_sticky: got err=%b busy=%b want 1/0", err, busy); end
    $display("backpressure: pend=5 dropped=7 next sum=34");
  endtask

  task automatic test_back_to_back();
    rise(1); fall();
    rise(1); fall();
    rise(1); fall();
    rise(1); fall();
    rise(5); fall();
    sum_ready = 1'b1;
    rise(6);
    sum_ready = 1'b0;
    n_cmp++; if (sum_valid !== 1'b0 || count !== 3'd2 || busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart: got valid=%b count=%0d busy=%b want 0/2/1", sum_valid, count, busy); end
    fall();
    rise(1); fall();
    rise(2);
    n_cmp++; if (sum_valid !== 1'b1 || sum_out !== 16'd14) begin n_err++; $display("FAIL b2b_sum: got valid=%b sum=%0d want 1/14", sum_valid, $signed(sum_out)); end
    fall();
    handshake();
    $display("back to back: pend 5 + cap 6 restart -> 14");
  endtask

  task automatic test_abort();
    rise(11); fall();
    rise(12); fall();
    clr       = 1'b1;
    prod_in   = 8'd50;
    prod_done = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++; if (count !== 3'd0 || busy !== 1'b0 || sum_valid !== 1'b0) begin n_err++; $display("FAIL abort_idle: got count=%0d busy=%b valid=%b want 0/0/0", count, busy, sum_valid); end
    fall();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL abort_discard: got count=%0d want 0", count); end
    rise(1); fall();
    rise(-2); fall();
    rise(3); fall();
    rise(100);
    n_cmp++; if (sum_valid !== 1'b1 || sum_out !== 16'd102 || count !== 3'd4) begin n_err++; $display("FAIL abort_fresh_sum: got valid=%b sum=%0d count=%0d want 1/102/4", sum_valid, $signed(sum_out), count); end
    fall();
    handshake();
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL abort_err_kept: got err=%b want 1", err); end
    $display("abort: fresh sum=102");
  endtask

  task automatic test_saturation();
    logic [7:0] exp_sum;
    logic       exp_ovf;
`ifdef BOOTH_MAC_SAT_EN
    exp_sum = 8'd127;
    exp_ovf = 1'b1;
`else
    exp_sum = 8'hC8;
    exp_ovf = 1'b0;
`endif
    d2_prod_in = 8'd100; d2_prod_done = 1'b1; tick();
    d2_prod_done = 1'b0; tick();
    d2_prod_in = 8'd100; d2_prod_done = 1'b1; tick();
    n_cmp++; if (d2_sum_valid !== 1'b1 || d2_sum_out !== exp_sum) begin n_err++; $display("FAIL sat_sum: got valid=%b sum=%0d want 1/%0d", d2_sum_valid, $signed(d2_sum_out), $signed(exp_sum)); end
    n_cmp++; if (d2_ovf !== exp_ovf) begin n_err++; $display("FAIL sat_ovf: got %b want %b", d2_ovf, exp_ovf); end
    d2_prod_done = 1'b0; tick();
    d2_prod_in = 8'd3; d2_prod_done = 1'b1; tick();
    d2_prod_done = 1'b0; tick();
    d2_sum_ready = 1'b1;
    d2_prod_in = 8'd4; d2_prod_done = 1'b1; tick();
    d2_sum_ready = 1'b0;
    n_cmp++; if (d2_sum_valid !== 1'b1 || d2_sum_out !== 8'd7 || d2_count !== 2'd2) begin n_err++; $display("FAIL len2_restart: got valid=%b sum=%0d count=%0d want 1/7/2", d2_sum_valid, $signed(d2_sum_out), d2_count); end
    d2_prod_done = 1'b0; tick();
    d2_sum_ready = 1'b1; tick();
    d2_sum_ready = 1'b0;
    n_cmp++; if (d2_busy !== 1'b0 || d2_err !== 1'b0 || d2_ovf !== exp_ovf) begin n_err++; $display("FAIL len2_idle: got busy=%b err=%b ovf=%b want 0/0/%b", d2_busy, d2_err, d2_ovf, exp_ovf); end
    $display("saturation: 100+100 -> %0d ovf=%b", $signed(d2_sum_out), d2_ovf);
  endtask

  initial begin
    rst          = 1'b1;
    prod_in      = '0;
    prod_done    = 1'b0;
    clr          = 1'b0;
    sum_ready    = 1'b0;
    d2_prod_in   = '0;
    d2_prod_done = 1'b0;
    d2_clr       = 1'b0;
    d2_sum_ready = 1'b0;
    test_reset();
    test_reset_done_high();
    test_basic_sum();
    test_held_done();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
